rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Owns the single register-file write port of the CPU.
- Two requesters share it:
  - the pipeline write-back stage, which has priority but can be stalled;
  - a long-latency unit (MUL/DIV, late load return), which uses a valid/ready handshake.
- Long-latency results are buffered in a small FIFO. A starvation counter forces the FIFO to drain.
- A hazard query port tells the hazard unit whether a register still has a write pending in this block.

Parameters:
- LL_DEPTH, 2, long-latency FIFO depth in entries (power of 2, ≥2).
- STARVE_LIMIT, 4, cycles the FIFO head may wait before the pipeline is stalled to service it.
- CNT_W, 3, width of the starvation counter (must hold STARVE_LIMIT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pipe_wr_i  in  1  WB stage write request
- pipe_addr_i  in  5  WB destination register
- pipe_data_i  in  32  WB write data (already muxed DM/ALU)
- pipe_stall_o  out  1  freeze pipeline this cycle; WB inputs must be held stable
- ll_valid_i  in  1  long-latency result valid
- ll_addr_i  in  5  long-latency destination register
- ll_data_i  in  32  long-latency result
- ll_ready_o  out  1  FIFO can accept (= !full)
- hz_addr_i  in  5  hazard query register
- hz_hit_o  out  1  query register has a pending write here
- reg_wr_o  out  1  register-file write enable
- addr_o  out  5  register-file write address
- data_o  out  32  register-file write data

Behaviour:

Reset (async, rst=1):
- FIFO emptied; read pointer, write pointer, count = 0; starvation counter = 0.
- reg_wr_o=0, addr_o=0, data_o=0.
- combinationally: pipe_stall_o=0, ll_ready_o=1, hz_hit_o=0.
- Reset mid-operation discards buffered entries. No write is issued for them.

Request validity:
- A pipe request is valid only if pipe_wr_i=1 and pipe_addr_i≠0. Writes to x0 are ignored and never stall.

FIFO:
- Push when ll_valid_i && ll_ready_o. ll_ready_o = (count<LL_DEPTH), computed combinationally.
- When full there is no push, even if a pop happens in the same cycle (no pass-through).
- Pointers wrap modulo LL_DEPTH. Entries leave in order.

Grant (combinational, evaluated each cycle, highest rule wins):
1. FORCE: FIFO non-empty and starve_cnt==STARVE_LIMIT. Grant the FIFO head and pop it. pipe_stall_o=1.
2. PIPE: a valid pipe request exists. Grant pipe; pipe_stall_o=0.
3. LL: FIFO non-empty. Grant the FIFO head and pop it.
4. IDLE: no grant.
- pipe_stall_o is 1 only under FORCE.

Head entry with rd=0:
- It is popped whenever granted, but no write is produced (reg_wr_o stays 0).

Output stage (1-cycle latency, registered):
- On a grant that carries a write: reg_wr_o←1, addr_o/data_o←granted values on the next edge.
- Otherwise reg_wr_o←0, and addr_o/data_o hold their previous values.

Starvation counter:
- Reset to 0 when the FIFO is empty or a pop occurs.
- Otherwise increment, saturating at STARVE_LIMIT.
- A push into an empty FIFO starts counting from 0 on the next cycle.

Hazard query (combinational):
- hz_hit_o=1 when hz_addr_i≠0 and either:
  - any valid FIFO entry has a matching rd; or
  - reg_wr_o=1 and addr_o==hz_addr_i (write in flight).
- Entries pushed in the current cycle are not visible until the next cycle.

Simultaneous events:
- Push and pop in the same cycle: count unchanged, both pointers advance.
- FORCE in the same cycle as a valid pipe request: the pipe request is not consumed. The WB stage re-presents it next cycle (pipeline frozen), and it wins under PIPE unless FORCE repeats.

Test Plan:
- Reset, then pipe_wr_i=1, addr=5, data=0xDEADBEEF for 1 cycle → next cycle reg_wr_o=1, addr_o=5, data_o=0xDEADBEEF; the cycle after, reg_wr_o=0.
- ll_valid_i for addr=7, data=0x11 while pipe idle → push; following cycle LL grant; one cycle later reg_wr_o=1, addr_o=7, data_o=0x11; ll_ready_o stays 1 throughout.
- Fill FIFO (two pushes: addr=3, addr=4) while the pipe writes every cycle → ll_ready_o=0 after the 2nd push; hz_hit_o=1 for hz_addr_i=3 and 4, and 0 for 6. After STARVE_LIMIT=4 waiting cycles, pipe_stall_o=1 for one cycle and addr 3 is written; addr 4 follows after a further 4 stalled-out cycles.
- Pipe write to x0 each cycle with a FIFO entry addr=9 → LL grant immediately; no stall; reg_wr_o never asserts for addr 0.
- FIFO entry with rd=0 → popped, reg_wr_o=0, count decrements, no stall.
- Two FIFO entries pending, rst pulsed mid-stream asynchronously (between edges) → outputs immediately 0, ll_ready_o=1, hz_hit_o=0; no writes after deassertion.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// Register-file write port bundle: WB request, long-latency
// handshake, hazard query and the registered write port.
interface rf_wr_arbiter_if;
    logic        pipe_wr_i;
    logic [4:0]  pipe_addr_i;
    logic [31:0] pipe_data_i;
    logic        pipe_stall_o;
    logic        ll_valid_i;
    logic [4:0]  ll_addr_i;
    logic [31:0] ll_data_i;
    logic        ll_ready_o;
    logic [4:0]  hz_addr_i;
    logic        hz_hit_o;
    logic        reg_wr_o;
    logic [4:0]  addr_o;
    logic [31:0] data_o;

    modport slave (
        input  pipe_wr_i, pipe_addr_i, pipe_data_i,
        input  ll_valid_i, ll_addr_i, ll_data_i,
        input  hz_addr_i,
        output pipe_stall_o, ll_ready_o, hz_hit_o,
        output reg_wr_o, addr_o, data_o
    );

    modport master (
        output pipe_wr_i, pipe_addr_i, pipe_data_i,
        output ll_valid_i, ll_addr_i, ll_data_i,
        output hz_addr_i,
        input  pipe_stall_o, ll_ready_o, hz_hit_o,
        input  reg_wr_o, addr_o, data_o
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write port arbiter: WB stage vs. buffered
// long-latency results, with starvation-forced drain.
module rf_wr_arbiter #(
    parameter int LL_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input logic           clk,
    input logic           rst,
    rf_wr_arbiter_if.slave bus
);
    localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(LL_DEPTH);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        G_IDLE, G_PIPE, G_LL, G_FORCE
    } grant_e;

    logic [4:0]       fifo_addr [LL_DEPTH];
    logic [31:0]      fifo_data [LL_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [CNT_W-1:0] starve_cnt;
    logic             reg_wr_q;
    logic [4:0]       addr_q;
    logic [31:0]      data_q;

    grant_e           grant;
    logic             empty, ready, push, pop, pipe_v;
    logic             win_wr;
    logic [4:0]       win_addr;
    logic [31:0]      win_data;
    logic             fifo_hit;
    logic [PTR_W-1:0] off;

    assign empty  = (count == '0);
    assign ready  = (count < FULL_CNT);
    assign push   = bus.ll_valid_i && ready;
    assign pipe_v = bus.pipe_wr_i && (bus.pipe_addr_i != 5'd0);
    assign pop    = (grant == G_FORCE) || (grant == G_LL);

    always_comb begin
        grant = G_IDLE;
        if (!empty && starve_cnt == LIMIT)
            grant = G_FORCE;
        else if (pipe_v)
            grant = G_PIPE;
        else if (!empty)
            grant = G_LL;
    end

    // An x0 head is still popped, it just never writes.
    always_comb begin
        win_wr   = 1'b0;
        win_addr = bus.pipe_addr_i;
        win_data = bus.pipe_data_i;
        unique case (1'b1)
            pop: begin
                win_addr = fifo_addr[rd_ptr];
                win_data = fifo_data[rd_ptr];
                win_wr   = (win_addr != 5'd0);
            end
            (grant == G_PIPE): win_wr = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        fifo_hit = 1'b0;
        off      = '0;
        for (int j = 0; j < LL_DEPTH; j++) begin
            off = PTR_W'(j) - rd_ptr;
            if ({1'b0, off} < count &&
                fifo_addr[j] == bus.hz_addr_i)
                fifo_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.ll_addr_i;
            fifo_data[wr_ptr] <= bus.ll_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push)
                           - (PTR_W+1)'(pop);
            if (empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            reg_wr_q <= win_wr;
            if (win_wr) begin
                addr_q <= win_addr;
                data_q <= win_data;
            end
        end
    end

    assign bus.pipe_stall_o = (grant == G_FORCE);
    assign bus.ll_ready_o   = ready;
    assign bus.reg_wr_o     = reg_wr_q;
    assign bus.addr_o       = addr_q;
    assign bus.data_o       = data_q;
    assign bus.hz_hit_o     = (bus.hz_addr_i != 5'd0) &&
        (fifo_hit || (reg_wr_q && addr_q == bus.hz_addr_i));
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: queue-based reference model plus
// directed sequences with hand-computed expectations.
module tb_rf_wr_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wr_arbiter_if bus();

    rf_wr_arbiter #(
        .LL_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          wait_c = 0;
    logic        m_wr = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    function automatic logic m_hit(input logic [4:0] h);
        logic r = 1'b0;
        foreach (q[i]) if (q[i].a == h) r = 1'b1;
        if (m_wr && m_addr == h) r = 1'b1;
        return (h != 5'd0) && r;
    endfunction

    // Reference model: compare mid-cycle, advance on the edge.
    initial begin : model
        int   n;
        logic force_g, pv, popped, g_wr;
        logic [4:0]  ga;
        logic [31:0] gd;
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n = q.size();
                chk("m_stall", 32'(bus.pipe_stall_o),
                    32'(n > 0 && wait_c == LIMIT));
                chk("m_ready", 32'(bus.ll_ready_o), 32'(n < DEPTH));
                chk("m_hz", 32'(bus.hz_hit_o),
                    32'(m_hit(bus.hz_addr_i)));
                chk("m_wr", 32'(bus.reg_wr_o), 32'(m_wr));
                chk("m_addr", 32'(bus.addr_o), 32'(m_addr));
                chk("m_data", bus.data_o, m_data);
            end
            @(posedge clk);
            if (rst) begin
                q.delete();
                wait_c = 0;
                m_wr   = 1'b0;
                m_addr = '0;
                m_data = '0;
            end else begin
                n       = q.size();
                force_g = (n > 0) && (wait_c == LIMIT);
                pv      = bus.pipe_wr_i && bus.pipe_addr_i != 0;
                popped  = 1'b0;
                g_wr    = 1'b0;
                ga      = '0;
                gd      = '0;
                if (force_g || (!pv && n > 0)) begin
                    e      = q.pop_front();
                    popped = 1'b1;
                    g_wr   = (e.a != 0);
                    ga     = e.a;
                    gd     = e.d;
                end else if (pv) begin
                    g_wr = 1'b1;
                    ga   = bus.pipe_addr_i;
                    gd   = bus.pipe_data_i;
                end
                if (bus.ll_valid_i && n < DEPTH) begin
                    e.a = bus.ll_addr_i;
                    e.d = bus.ll_data_i;
                    q.push_back(e);
                end
                if (n == 0 || popped)
                    wait_c = 0;
                else if (wait_c < LIMIT)
                    wait_c = wait_c + 1;
                m_wr = g_wr;
                if (g_wr) begin
                    m_addr = ga;
                    m_data = gd;
                end
            end
        end
    end

    task automatic drv(input logic pw, input logic [4:0] pa,
                       input logic [31:0] pd, input logic lv,
                       input logic [4:0] la, input logic [31:0] ld);
        bus.pipe_wr_i   = pw;
        bus.pipe_addr_i = pa;
        bus.pipe_data_i = pd;
        bus.ll_valid_i  = lv;
        bus.ll_addr_i   = la;
        bus.ll_data_i   = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [4:0] pa;
    logic       exp_st;

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        bus.hz_addr_i = 5'd3;
        @(posedge clk);
        #1;
        chk("rst_wr", 32'(bus.reg_wr_o), 0);
        chk("rst_addr", 32'(bus.addr_o), 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_ready", 32'(bus.ll_ready_o), 1);
        chk("rst_stall", 32'(bus.pipe_stall_o), 0);
        chk("rst_hz", 32'(bus.hz_addr_i == 3 && bus.hz_hit_o), 0);
        step();
        step();
        rst = 1'b0;
        bus.hz_addr_i = 5'd0;

        // Single pipe write
        drv(1, 5, 32'hDEADBEEF, 0, 0, 0);
        mid(); chk("p_stall", 32'(bus.pipe_stall_o), 0);
        step();
        drv(0, 0, 0, 0, 0, 0);
        mid();
        chk("p_wr", 32'(bus.reg_wr_o), 1);
        chk("p_addr", 32'(bus.addr_o), 5);
        chk("p_data", bus.data_o, 32'hDEADBEEF);
        step();
        mid(); chk("p_wr_off", 32'(bus.reg_wr_o), 0);
        step();

        // Single long-latency result
        drv(0, 0, 0, 1, 7, 32'h11);
        bus.hz_addr_i = 5'd7;
        mid(); chk("l_ready0", 32'(bus.ll_ready_o), 1);
        step();
        drv(0, 0, 0, 0, 0, 0);
        mid();
        chk("l_ready1", 32'(bus.ll_ready_o), 1);
        chk("l_hz_fifo", 32'(bus.hz_hit_o), 1);
        step();
        mid();
        chk("l_wr", 32'(bus.reg_wr_o), 1);
        chk("l_addr", 32'(bus.addr_o), 7);
        chk("l_data", bus.data_o, 32'h11);
        chk("l_hz_fly", 32'(bus.hz_hit_o), 1);
        chk("l_ready2", 32'(bus.ll_ready_o), 1);
        step();
        bus.hz_addr_i = 5'd0;
        step();

        // Starvation: pipe busy every cycle, two buffered entries
        pa = 5'd10;
        drv(1, pa, 32'(pa), 1, 3, 32'h33);
        mid(); chk("s_ready0", 32'(bus.ll_ready_o), 1);
        step(); pa++;
        drv(1, pa, 32'(pa), 1, 4, 32'h44);
        mid(); chk("s_ready1", 32'(bus.ll_ready_o), 1);
        step(); pa++;
        for (int k = 0; k < 11; k++) begin
            drv(1, pa, 32'(pa), 0, 0, 0);
            mid();
            exp_st = (k == 3 || k == 8);
            chk($sformatf("s_stall%0d", k),
                32'(bus.pipe_stall_o), 32'(exp_st));
            if (k == 0) begin
                chk("s_full", 32'(bus.ll_ready_o), 0);
                bus.hz_addr_i = 5'd3; #1;
                chk("s_hz3", 32'(bus.hz_hit_o), 1);
                bus.hz_addr_i = 5'd4; #1;
                chk("s_hz4", 32'(bus.hz_hit_o), 1);
                bus.hz_addr_i = 5'd6; #1;
                chk("s_hz6", 32'(bus.hz_hit_o), 0);
                bus.hz_addr_i = 5'd0;
            end
            if (k == 4) begin
                chk("s_f1_wr", 32'(bus.reg_wr_o), 1);
                chk("s_f1_addr", 32'(bus.addr_o), 3);
                chk("s_f1_data", bus.data_o, 32'h33);
            end
            if (k == 9) begin
                chk("s_f2_addr", 32'(bus.addr_o), 4);
                chk("s_f2_data", bus.data_o, 32'h44);
            end
            step();
            if (!exp_st) pa++;
        end
        drv(0, 0, 0, 0, 0, 0);
        step();
        step();

        // Pipe writes to x0 never block the FIFO
        drv(1, 0, 32'h5, 1, 9, 32'h99);
        mid(); chk("z_stall0", 32'(bus.pipe_stall_o), 0);
        step();
        drv(1, 0, 32'h5, 0, 0, 0);
        mid();
        chk("z_wr0", 32'(bus.reg_wr_o), 0);
        chk("z_stall1", 32'(bus.pipe_stall_o), 0);
        step();
        mid();
        chk("z_wr1", 32'(bus.reg_wr_o), 1);
        chk("z_addr", 32'(bus.addr_o), 9);
        chk("z_data", bus.data_o, 32'h99);
        step();
        mid(); chk("z_wr2", 32'(bus.reg_wr_o), 0);
        step();

        // Entries targeting x0 drain silently
        drv(1, 15, 32'hF, 1, 0, 32'h55);
        step();
        drv(1, 16, 32'h10, 1, 0, 32'h66);
        step();
        drv(0, 0, 0, 0, 0, 0);
        mid(); chk("r0_full", 32'(bus.ll_ready_o), 0);
        step();
        mid();
        chk("r0_ready", 32'(bus.ll_ready_o), 1);
        chk("r0_wr0", 32'(bus.reg_wr_o), 0);
        step();
        mid();
        chk("r0_wr1", 32'(bus.reg_wr_o), 0);
        chk("r0_stall", 32'(bus.pipe_stall_o), 0);
        step();

        // Asynchronous reset with two entries buffered
        drv(1, 17, 32'h17, 1, 12, 32'hC);
        step();
        drv(1, 18, 32'h18, 1, 13, 32'hD);
        step();
        drv(1, 19, 32'h19, 0, 0, 0);
        bus.hz_addr_i = 5'd12;
        mid();
        chk("a_hz_pre", 32'(bus.hz_hit_o), 1);
        chk("a_full_pre", 32'(bus.ll_ready_o), 0);
        #2 rst = 1'b1;
        #1;
        chk("a_wr", 32'(bus.reg_wr_o), 0);
        chk("a_addr", 32'(bus.addr_o), 0);
        chk("a_data", bus.data_o, 0);
        chk("a_ready", 32'(bus.ll_ready_o), 1);
        chk("a_hz", 32'(bus.hz_hit_o), 0);
        chk("a_stall", 32'(bus.pipe_stall_o), 0);
        drv(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk($sformatf("a_post_wr%0d", k),
                32'(bus.reg_wr_o), 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
